// File: rtl/isa_pkg.sv
// isa_pkg: shared ECE550 ISA constants for the instruction encoder and the
// processor's control decoder.
//   - opcode and R-type ALU op constants
//   - instruction field bit positions
//   - instruction format enum plus an opcode-to-format helper
package isa_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRA  = 5'b00101;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned IMM_W     = 17;
    localparam int unsigned TARGET_W  = 27;
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_LSB    = 17;
    localparam int unsigned RT_LSB    = 12;
    localparam int unsigned SHAMT_LSB = 7;
    localparam int unsigned ALUOP_LSB = 2;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_JI,
        FMT_JII,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e fmt_of(input logic [4:0] op);
        fmt_e f;
        case (op)
            OP_RTYPE:                         f = FMT_R;
            OP_ADDI, OP_SW, OP_LW,
            OP_BNE, OP_BLT:                   f = FMT_I;
            OP_J, OP_JAL, OP_SETX, OP_BEX:    f = FMT_JI;
            OP_JR:                            f = FMT_JII;
            default:                          f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/insn_pack.sv
// insn_pack: combinational packer from a decoded descriptor to a 32-bit
// ECE550 instruction word. Fields not used by the format are forced to 0.
// Ports:
//   opcode_i, aluop_i, rd_i, rs_i, rt_i, shamt_i : 5-bit descriptor fields
//   imm_i    : 17-bit immediate (I format)
//   target_i : 27-bit target (JI format)
//   word_o   : packed instruction word
//   legal_o  : 1 when the opcode is known and, for R-type, aluop <= SRA
module insn_pack
    import isa_pkg::*;
(
    input  logic [4:0]          opcode_i,
    input  logic [4:0]          aluop_i,
    input  logic [4:0]          rd_i,
    input  logic [4:0]          rs_i,
    input  logic [4:0]          rt_i,
    input  logic [4:0]          shamt_i,
    input  logic [IMM_W-1:0]    imm_i,
    input  logic [TARGET_W-1:0] target_i,
    output logic [31:0]         word_o,
    output logic                legal_o
);

    fmt_e fmt;

    assign fmt = fmt_of(opcode_i);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b0;
        case (fmt)
            FMT_R: begin
                word_o[OP_LSB    +: REG_W] = opcode_i;
                word_o[RD_LSB    +: REG_W] = rd_i;
                word_o[RS_LSB    +: REG_W] = rs_i;
                word_o[RT_LSB    +: REG_W] = rt_i;
                word_o[SHAMT_LSB +: REG_W] = shamt_i;
                word_o[ALUOP_LSB +: REG_W] = aluop_i;
                legal_o                    = (aluop_i <= ALU_SRA);
            end
            FMT_I: begin
                word_o[OP_LSB +: REG_W] = opcode_i;
                word_o[RD_LSB +: REG_W] = rd_i;
                word_o[RS_LSB +: REG_W] = rs_i;
                word_o[0      +: IMM_W] = imm_i;
                legal_o                 = 1'b1;
            end
            FMT_JI: begin
                word_o[OP_LSB +: REG_W]    = opcode_i;
                word_o[0      +: TARGET_W] = target_i;
                legal_o                    = 1'b1;
            end
            FMT_JII: begin
                word_o[OP_LSB +: REG_W] = opcode_i;
                word_o[RD_LSB +: REG_W] = rd_i;
                legal_o                 = 1'b1;
            end
            default: begin
                word_o  = '0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/insn_encoder.sv
// insn_encoder: sequential loader that packs one descriptor per handshake
// into an ECE550 word and writes it to consecutive instruction-memory
// addresses starting at a programmable base.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start, start_addr   : arm the loader (ignored while loading)
//   finish              : end the program while loading
//   in_valid, in_ready  : descriptor handshake; in_ready is high only in LOAD
//   in_opcode .. in_target : descriptor fields
//   imem_wren/addr/data : registered write port, one pulse per word
//   count               : words written since the last start
//   busy, done, full    : LOAD / DONE / FULL state flags
//   err_illegal         : sticky, set by an illegal descriptor
module insn_encoder
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic                finish,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          in_opcode,
    input  logic [4:0]          in_aluop,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs,
    input  logic [4:0]          in_rt,
    input  logic [4:0]          in_shamt,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [TARGET_W-1:0] in_target,
    output logic                imem_wren,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_data,
    output logic [ADDR_W:0]     count,
    output logic                busy,
    output logic                done,
    output logic                full,
    output logic                err_illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_FULL
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;

    logic [31:0]         pack_word;
    logic                pack_legal;
    logic                accept;
    logic                write;

    insn_pack u_pack (
        .opcode_i (in_opcode),
        .aluop_i  (in_aluop),
        .rd_i     (in_rd),
        .rs_i     (in_rs),
        .rt_i     (in_rt),
        .shamt_i  (in_shamt),
        .imm_i    (in_imm),
        .target_i (in_target),
        .word_o   (pack_word),
        .legal_o  (pack_legal)
    );

    assign accept = in_valid && (state_q == S_LOAD);
    assign write  = accept && pack_legal;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        err_d     = err_q;
        wren_d    = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        case (state_q)
            S_LOAD: begin
                if (write) begin
                    wren_d    = 1'b1;
                    addr_d    = wr_addr_q;
                    data_d    = pack_word;
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                    count_d   = count_q + CNT_ONE;
                end else if (accept) begin
                    err_d = 1'b1;
                end
                // Writing the last address wins over a simultaneous finish;
                // wr_addr wraps here but is reloaded by the next start.
                if (write && (wr_addr_q == '1)) begin
                    state_d = S_FULL;
                end else if (finish) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                if (start) begin
                    state_d   = S_LOAD;
                    wr_addr_d = start_addr;
                    count_d   = '0;
                    err_d     = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            err_q     <= err_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign in_ready    = (state_q == S_LOAD);
    assign busy        = (state_q == S_LOAD);
    assign done        = (state_q == S_DONE);
    assign full        = (state_q == S_FULL);
    assign err_illegal = err_q;
    assign imem_wren   = wren_q;
    assign imem_addr   = addr_q;
    assign imem_data   = data_q;
    assign count       = count_q;

endmodule
